// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
package pipe_ctrl_pkg;

  // EX operand source select encodings
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // One pipeline mode per cycle: advance, load-use bubble, branch flush, memory stall
  typedef enum logic [1:0] {
    ADV    = 2'd0,
    LDU    = 2'd1,
    FLUSH  = 2'd2,
    MSTALL = 2'd3
  } mode_t;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_fwd_sel.sv
// Forward-source compare for one EX operand; EX/MEM result beats MEM/WB result.
module pipe_fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RDW = 3
) (
  input  logic [RDW-1:0] src,
  input  logic           mem_v,
  input  logic           mem_regwrite,
  input  logic [RDW-1:0] mem_rd,
  input  logic           wb_v,
  input  logic           wb_regwrite,
  input  logic [RDW-1:0] wb_rd,
  output logic [1:0]     sel_c
);

  logic mem_hit;
  logic wb_hit;

  // Register 0 is hardwired zero and never a forwarding source; invalid stages never forward
  always_comb begin
    mem_hit = mem_v & mem_regwrite & (mem_rd != '0) & (mem_rd == src);
    wb_hit  = wb_v & wb_regwrite & (wb_rd != '0) & (wb_rd == src);
    sel_c   = FWD_REG;
    if (mem_hit) begin
      sel_c = FWD_MEM;
    end else if (wb_hit) begin
      sel_c = FWD_WB;
    end
  end

endmodule : pipe_fwd_sel

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stage valid bits, enables/bubbles, forwarding, MEM-stall watchdog.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined; otherwise tied to 0.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_DIR_WIDTH = 3,
  parameter int unsigned MEM_TIMEOUT   = 255,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_DIR_WIDTH-1:0] id_rs,
  input  logic [REG_DIR_WIDTH-1:0] id_rt,
  input  logic                     id_use_rs,
  input  logic                     id_use_rt,
  input  logic [REG_DIR_WIDTH-1:0] ex_rs,
  input  logic [REG_DIR_WIDTH-1:0] ex_rt,
  input  logic [REG_DIR_WIDTH-1:0] ex_rd,
  input  logic                     ex_memread,
  input  logic                     ex_br_taken,
  input  logic [REG_DIR_WIDTH-1:0] mem_rd,
  input  logic [REG_DIR_WIDTH-1:0] wb_rd,
  input  logic                     mem_regwrite,
  input  logic                     wb_regwrite,
  input  logic                     mem_req,
  input  logic                     mem_ack,
  output logic                     pc_write,
  output logic                     ifid_write,
  output logic                     ifid_flush,
  output logic                     idex_bubble,
  output logic                     front_hold,
  output logic                     memwb_bubble,
  output logic                     v_id,
  output logic                     v_ex,
  output logic                     v_mem,
  output logic                     v_wb,
  output logic [1:0]               fwd_a,
  output logic [1:0]               fwd_b,
  output logic                     mem_err,
  output logic [CNT_WIDTH-1:0]     cyc_cnt,
  output logic [CNT_WIDTH-1:0]     stall_cnt,
  output logic [CNT_WIDTH-1:0]     flush_cnt
);

  localparam int unsigned       WD_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_MAX = WD_W'(MEM_TIMEOUT);

  mode_t           mode;
  logic            mem_stall;
  logic            flush;
  logic            load_use;
  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_inc;

  // Hazard detection and mode selection: mem_stall > flush > load_use > advance
  always_comb begin
    mem_stall = v_mem & mem_req & ~mem_ack;
    flush     = v_ex & ex_br_taken & ~mem_stall;
    load_use  = v_id & v_ex & ex_memread & (ex_rd != '0) &
                ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
    mode      = ADV;
    if (mem_stall) begin
      mode = MSTALL;
    end else if (flush) begin
      mode = FLUSH;
    end else if (load_use) begin
      mode = LDU;
    end
  end

  // Pipeline-register enables and bubbles for the current mode
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    front_hold   = 1'b0;
    memwb_bubble = 1'b0;
    case (mode)
      MSTALL: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        front_hold   = 1'b1;
        memwb_bubble = 1'b1;
      end
      FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      LDU: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage valid bits follow the instruction flow chosen by the mode
  always_ff @(posedge clk) begin
    if (rst) begin
      v_id  <= 1'b0;
      v_ex  <= 1'b0;
      v_mem <= 1'b0;
      v_wb  <= 1'b0;
    end else begin
      case (mode)
        MSTALL: begin
          v_wb <= 1'b0;
        end
        FLUSH: begin
          v_id  <= 1'b0;
          v_ex  <= 1'b0;
          v_mem <= 1'b1;
          v_wb  <= v_mem;
        end
        LDU: begin
          v_ex  <= 1'b0;
          v_mem <= v_ex;
          v_wb  <= v_mem;
        end
        default: begin
          v_id  <= 1'b1;
          v_ex  <= v_id;
          v_mem <= v_ex;
          v_wb  <= v_mem;
        end
      endcase
    end
  end

  // Saturating increment of the consecutive-stall count
  always_comb begin
    wd_inc = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + WD_W'(1);
  end

  // Watchdog: consecutive MEM stalls; mem_err is sticky once the limit is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      mem_err <= 1'b0;
    end else if (mode == MSTALL) begin
      wd_cnt <= wd_inc;
      if (wd_inc == WD_MAX) begin
        mem_err <= 1'b1;
      end
    end else begin
      wd_cnt <= '0;
    end
  end

  pipe_fwd_sel #(.RDW(REG_DIR_WIDTH)) u_fwd_a (
    .src          (ex_rs),
    .mem_v        (v_mem),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_v         (v_wb),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .sel_c        (fwd_a)
  );

  pipe_fwd_sel #(.RDW(REG_DIR_WIDTH)) u_fwd_b (
    .src          (ex_rt),
    .mem_v        (v_mem),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_v         (v_wb),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .sel_c        (fwd_b)
  );

`ifdef PIPE_PERF_CNT_EN
  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (cyc_cnt != '1) begin
        cyc_cnt <= cyc_cnt + CNT_WIDTH'(1);
      end
      if ((mode == MSTALL || mode == LDU) && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
      if (mode == FLUSH && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
      end
    end
  end
`else
  assign cyc_cnt   = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: behavioural pipeline model checked every cycle plus directed literal checks.
module tb_pipe_ctrl;

  localparam int RDW   = 3;
  localparam int TMO   = 4;
  localparam int CNT_W = 16;

  logic clk;
  logic rst;
  logic [RDW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_use_rs, id_use_rt, ex_memread, ex_br_taken;
  logic mem_regwrite, wb_regwrite, mem_req, mem_ack;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, front_hold, memwb_bubble;
  logic v_id, v_ex, v_mem, v_wb, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt;

  pipe_ctrl #(.REG_DIR_WIDTH(RDW), .MEM_TIMEOUT(TMO), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_br_taken(ex_br_taken), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .front_hold(front_hold), .memwb_bubble(memwb_bubble),
    .v_id(v_id), .v_ex(v_ex), .v_mem(v_mem), .v_wb(v_wb),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit armed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pipeline occupancy as four flags (IF/ID, ID/EX, EX/MEM, MEM/WB), stall run length, counters.
  bit m_v[4];
  int m_run;
  bit m_err;
  int m_cyc, m_stall, m_flush;

  // 3 = memory stall, 2 = branch flush, 1 = load-use, 0 = advance
  function automatic int calc_mode();
    bit ms, fl, lu;
    ms = m_v[2] && mem_req && !mem_ack;
    fl = m_v[1] && ex_br_taken && !ms;
    lu = m_v[0] && m_v[1] && ex_memread && ex_rd != 0 &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    if (ms) return 3;
    if (fl) return 2;
    if (lu) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] calc_fwd(input logic [RDW-1:0] src);
    if (m_v[2] && mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'b10;
    if (m_v[3] && wb_regwrite && wb_rd != 0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat_inc(input int x);
    return (x < (1 << CNT_W) - 1) ? x + 1 : x;
  endfunction

  // Model state update on the active edge
  always @(posedge clk) begin
    int md;
    md = calc_mode();
    if (rst) begin
      m_v <= '{0, 0, 0, 0};
      m_run <= 0; m_err <= 0;
      m_cyc <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      m_cyc <= sat_inc(m_cyc);
      if (md == 3 || md == 1) m_stall <= sat_inc(m_stall);
      if (md == 2) m_flush <= sat_inc(m_flush);
      if (md == 3) begin
        m_run <= (m_run < TMO) ? m_run + 1 : m_run;
        if (m_run + 1 >= TMO) m_err <= 1;
        m_v[3] <= 0;
      end else begin
        m_run <= 0;
        if (md == 2) begin
          m_v <= '{0, 0, 1, m_v[2]};
        end else if (md == 1) begin
          m_v <= '{m_v[0], 0, m_v[1], m_v[2]};
        end else begin
          m_v <= '{1, m_v[0], m_v[1], m_v[2]};
        end
      end
    end
  end

  // Compare process: every output against the model, away from the active edge
  int e_md;
  always @(negedge clk) begin
    if (armed) begin
      e_md = calc_mode();
      chk("pc_write", pc_write, (e_md == 0 || e_md == 2) ? 1 : 0);
      chk("ifid_write", ifid_write, (e_md == 0 || e_md == 2) ? 1 : 0);
      chk("ifid_flush", ifid_flush, (e_md == 2) ? 1 : 0);
      chk("idex_bubble", idex_bubble, (e_md == 2 || e_md == 1) ? 1 : 0);
      chk("front_hold", front_hold, (e_md == 3) ? 1 : 0);
      chk("memwb_bubble", memwb_bubble, (e_md == 3) ? 1 : 0);
      chk("v_id", v_id, m_v[0]);
      chk("v_ex", v_ex, m_v[1]);
      chk("v_mem", v_mem, m_v[2]);
      chk("v_wb", v_wb, m_v[3]);
      chk("fwd_a", fwd_a, calc_fwd(ex_rs));
      chk("fwd_b", fwd_b, calc_fwd(ex_rt));
      chk("mem_err", mem_err, m_err);
`ifdef PIPE_PERF_CNT_EN
      chk("cyc_cnt", cyc_cnt, m_cyc);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
`else
      chk("cyc_cnt", cyc_cnt, 0);
      chk("stall_cnt", stall_cnt, 0);
      chk("flush_cnt", flush_cnt, 0);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_v(input string name, input logic [3:0] exp);
    chk(name, {v_id, v_ex, v_mem, v_wb}, exp);
  endtask

  initial begin
    rst = 1;
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_memread = 0; ex_br_taken = 0;
    mem_rd = 0; wb_rd = 0; mem_regwrite = 0; wb_regwrite = 0;
    mem_req = 0; mem_ack = 0;

    // Reset state
    step(2);
    armed = 1;
    settle();
    chk_v("reset_valid", 4'b0000);
    chk("reset_pc_write", pc_write, 1);
    chk("reset_mem_err", mem_err, 0);
    chk("reset_cyc_cnt", cyc_cnt, 0);

    // Fill: valid bits appear one stage per cycle
    rst = 0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      settle();
      chk_v("fill_valid", (4'b1111 << (4 - i)) & 4'b1111);
      chk("fill_pc_write", pc_write, 1);
    end

    // Load-use: load writes r3, ID reads r3
    ex_memread = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1;
    settle();
    chk("ldu_pc_write", pc_write, 0);
    chk("ldu_idex_bubble", idex_bubble, 1);
    chk("ldu_ifid_write", ifid_write, 0);
    step(1);
    ex_memread = 0; id_use_rs = 0;
    settle();
    chk_v("ldu_after_valid", 4'b1011);
    // Consumer reaches EX while the load sits in WB
    step(1);
    ex_rs = 3; wb_rd = 3; wb_regwrite = 1; mem_regwrite = 0;
    settle();
    chk("ldu_consumer_fwd_a", fwd_a, 2'b01);

    // Forwarding priority with both later stages valid
    step(2);
    mem_rd = 5; wb_rd = 5; mem_regwrite = 1; wb_regwrite = 1; ex_rs = 5; ex_rt = 5;
    settle();
    chk_v("fwd_valid", 4'b1111);
    chk("fwd_a_mem", fwd_a, 2'b10);
    chk("fwd_b_mem", fwd_b, 2'b10);
    mem_rd = 0;
    settle();
    chk("fwd_a_wb", fwd_a, 2'b01);
    ex_rs = 0;
    settle();
    chk("fwd_a_r0", fwd_a, 2'b00);
    mem_regwrite = 0; wb_regwrite = 0;

    // Branch taken together with a load-use hazard: flush wins
    ex_br_taken = 1; ex_memread = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1;
    settle();
    chk("br_ifid_flush", ifid_flush, 1);
    chk("br_idex_bubble", idex_bubble, 1);
    chk("br_pc_write", pc_write, 1);
    step(1);
    ex_br_taken = 0; ex_memread = 0; id_use_rs = 0;
    settle();
    chk_v("br_after_valid", 4'b0011);
`ifdef PIPE_PERF_CNT_EN
    chk("br_flush_cnt", flush_cnt, 1);
`else
    chk("br_flush_cnt", flush_cnt, 0);
`endif

    // Three-cycle memory stall, then acknowledge
    mem_req = 1; mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ms_front_hold", front_hold, 1);
      chk("ms_pc_write", pc_write, 0);
      step(1);
      chk("ms_v_wb", v_wb, 0);
      chk("ms_v_mem", v_mem, 1);
    end
    mem_ack = 1;
    settle();
    chk("ms_ack_front_hold", front_hold, 0);
    chk("ms_ack_pc_write", pc_write, 1);
`ifdef PIPE_PERF_CNT_EN
    chk("ms_stall_cnt", stall_cnt, 4);
`else
    chk("ms_stall_cnt", stall_cnt, 0);
`endif
    step(1);
    mem_req = 0; mem_ack = 0;
    settle();
    chk("ms_no_err_below_limit", mem_err, 0);

    // Refill the pipe, then stall past the watchdog limit
    step(2);
    settle();
    chk("wd_v_mem", v_mem, 1);
    mem_req = 1; mem_ack = 0;
    for (int i = 0; i < TMO; i++) begin
      settle();
      chk("wd_err_early", mem_err, 0);
      step(1);
    end
    chk("wd_err_set", mem_err, 1);
    chk("wd_still_stalling", front_hold, 1);
    mem_ack = 1;
    step(1);
    chk("wd_err_sticky", mem_err, 1);

    // Reset in the middle of a stall
    mem_ack = 0;
    settle();
    chk("rst_mid_stall_hold", front_hold, 1);
    step(1);
    rst = 1;
    step(1);
    settle();
    chk_v("rst_mid_valid", 4'b0000);
    chk("rst_mid_err", mem_err, 0);
    chk("rst_mid_front_hold", front_hold, 0);
    chk("rst_mid_pc_write", pc_write, 1);
    rst = 0; mem_req = 0;
    step(1);
    settle();
    chk_v("post_rst_valid", 4'b1000);
    step(2);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_ctrl
